// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-RAM access unit:
// funct3 codes, FSM states and the request legality check.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WRITE    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    function automatic logic access_err(
        input logic       store,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic mis;
        logic ill;
        mis = ((f3[1:0] == 2'd1) && off[0])
           || ((f3[1:0] == 2'd2) && (off != 2'd0));
        ill = store ? (f3 > 3'd2)
                    : ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
        return mis | ill;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-RAM bundle of the access unit.
// slave = the unit, master = the execute stage / RAM side.
interface mem_access_unit_if #(
    parameter int N = 32
);
    logic         req_valid;
    logic         req_ready;
    logic         req_store;
    logic [2:0]   req_funct3;
    logic [N-1:0] req_addr;
    logic [N-1:0] req_wdata;
    logic         rsp_valid;
    logic [N-1:0] rsp_rdata;
    logic         rsp_err;
    logic         ram_we;
    logic [N-1:0] ram_addr;
    logic [N-1:0] ram_wdata;
    logic [N-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit_lane.sv
// Byte/half lane handling: load extract+extend and
// store merge into an existing word, little-endian.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [4:0]  w_sh;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    assign w_sh   = {i_off, 3'b000};
    assign w_lane = i_word >> w_sh;
    assign w_ins  = i_wdata << w_sh;

    always_comb begin
        o_load = i_word;
        unique case (1'b1)
            (i_funct3 == F3_B):  o_load = {{24{w_lane[7]}}, w_lane[7:0]};
            (i_funct3 == F3_H):  o_load = {{16{w_lane[15]}}, w_lane[15:0]};
            (i_funct3 == F3_BU): o_load = {24'd0, w_lane[7:0]};
            (i_funct3 == F3_HU): o_load = {16'd0, w_lane[15:0]};
            default:             o_load = i_word;
        endcase
    end

    always_comb begin
        w_mask = '1;
        unique case (1'b1)
            (i_funct3[1:0] == 2'd0): w_mask = 32'h0000_00FF << w_sh;
            (i_funct3[1:0] == 2'd1): w_mask = 32'h0000_FFFF << w_sh;
            default:                 w_mask = '1;
        endcase
    end

    assign o_merge = (i_word & ~w_mask) | (w_ins & w_mask);

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide synchronous data RAM;
// sub-word stores are done as read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic               clk,
    input  logic               rstn,
    mem_access_unit_if.slave   bus
);

    state_t       r_state;
    state_t       w_next;
    logic         r_store;
    logic [2:0]   r_f3;
    logic [N-1:0] r_addr;
    logic [N-1:0] r_wword;
    logic [N-1:0] r_rdata;
    logic         r_err;

    logic         w_acc;
    logic         w_bad;
    logic         w_sw;
    logic [N-1:0] w_waddr;
    logic [N-1:0] w_load;
    logic [N-1:0] w_merge;

    assign w_acc   = bus.req_valid & bus.req_ready;
    assign w_bad   = access_err(bus.req_store, bus.req_funct3,
                                bus.req_addr[1:0]);
    assign w_sw    = bus.req_store && (bus.req_funct3 == F3_W);
    assign w_waddr = {r_addr[N-1:2], 2'b00};

    mem_lane_align u_lane (
        .i_word   (bus.ram_rdata),
        .i_wdata  (r_wword),
        .i_funct3 (r_f3),
        .i_off    (r_addr[1:0]),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_bad)     w_next = S_RESP;
                    else if (w_sw) w_next = S_WRITE;
                    else           w_next = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: w_next = S_RD_DATA;
            S_RD_DATA:  w_next = r_store ? S_WRITE : S_RESP;
            S_WRITE:    w_next = S_RESP;
            S_RESP:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // r_wword starts as the store data; sub-word stores replace it
    // with the merged word once the old word has been read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_store <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wword <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_acc) begin
                r_store <= bus.req_store;
                r_f3    <= bus.req_funct3;
                r_addr  <= bus.req_addr;
                r_wword <= bus.req_wdata;
                r_rdata <= '0;
                r_err   <= w_bad;
            end
            if (r_state == S_RD_DATA) begin
                if (r_store) r_wword <= w_merge;
                else         r_rdata <= w_load;
            end
        end
    end

    assign bus.req_ready = (r_state == S_IDLE) & rstn;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.ram_we    = (r_state == S_WRITE);
    assign bus.ram_addr  = ((r_state == S_RD_ISSUE) || (r_state == S_WRITE))
                         ? w_waddr : '0;
    assign bus.ram_wdata = (r_state == S_WRITE) ? r_wword : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM model, transaction-level reference
// model with per-cycle compare, plus literal pins from hand calculation.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr[7:2]] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr[7:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int nrsp = 0;

    logic [31:0] ref_mem [0:63];
    bit          pend_r, pend_w, pend_ri;
    int          acc_cyc, r_cyc, w_cyc, ri_cyc;
    logic [31:0] e_rdata, e_addr, e_wdata;
    bit          e_err;
    logic [31:0] hold_rdata = '0;
    bit          hold_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit m_err(input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
        int w;
        w = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        if (st && f3 > 3'd2) return 1'b1;
        if (!st && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        return (int'(a[1:0]) % w) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
        logic [31:0]        s;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        s  = word >> (8 * off);
        sb = s[7:0];
        sh = s[15:0];
        case (f3)
            3'd0:    r = sb;
            3'd1:    r = sh;
            3'd4:    r = {24'd0, s[7:0]};
            3'd5:    r = {16'd0, s[15:0]};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] old,
                                            input logic [31:0] wd,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [31:0] m;
        m = (f3 == 3'd0) ? 32'hFF : 32'hFFFF;
        m = m << (8 * off);
        return (old & ~m) | ((wd << (8 * off)) & m);
    endfunction

    task automatic model_accept(input bit st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd);
        acc_cyc = cyc;
        pend_r  = 1;
        pend_w  = 0;
        pend_ri = 0;
        e_addr  = {a[31:2], 2'b00};
        e_rdata = '0;
        e_err   = 0;
        if (m_err(st, f3, a)) begin
            e_err = 1;
            r_cyc = cyc + 1;
        end else if (st && f3 == 3'd2) begin
            pend_w  = 1;
            w_cyc   = cyc + 1;
            e_wdata = wd;
            r_cyc   = cyc + 2;
        end else if (st) begin
            pend_ri = 1;
            ri_cyc  = cyc + 1;
            pend_w  = 1;
            w_cyc   = cyc + 3;
            e_wdata = m_merge(ref_mem[a[7:2]], wd, f3, a[1:0]);
            r_cyc   = cyc + 4;
        end else begin
            pend_ri = 1;
            ri_cyc  = cyc + 1;
            e_rdata = m_load(ref_mem[a[7:2]], f3, a[1:0]);
            r_cyc   = cyc + 3;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_rdata", bus.rsp_rdata, 0);
            chk("rst_rsp_err", bus.rsp_err, 0);
            chk("rst_ram_we", bus.ram_we, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_ram_wdata", bus.ram_wdata, 0);
            pend_r = 0;
            pend_w = 0;
            pend_ri = 0;
            hold_rdata = '0;
            hold_err = 0;
        end else begin
            bit we_e, rv_e, ri_e;
            if (pend_r && cyc == acc_cyc + 1) begin
                hold_rdata = '0;
                hold_err = 0;
            end
            we_e = pend_w && cyc == w_cyc;
            rv_e = pend_r && cyc == r_cyc;
            ri_e = pend_ri && cyc == ri_cyc;
            chk("req_ready", bus.req_ready, !(pend_r && cyc > acc_cyc));
            chk("ram_we", bus.ram_we, we_e);
            chk("rsp_valid", bus.rsp_valid, rv_e);
            chk("ram_addr", bus.ram_addr, (we_e || ri_e) ? e_addr : 32'd0);
            chk("ram_wdata", bus.ram_wdata, we_e ? e_wdata : 32'd0);
            if (we_e) begin
                ref_mem[e_addr[7:2]] = e_wdata;
                pend_w = 0;
            end
            if (rv_e) begin
                hold_rdata = e_rdata;
                hold_err = e_err;
                pend_r = 0;
                pend_ri = 0;
                nrsp++;
            end
            chk("rsp_rdata", bus.rsp_rdata, hold_rdata);
            chk("rsp_err", bus.rsp_err, hold_err);
        end
    end

    task automatic do_req(input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit drop);
        bit ok;
        ok = 0;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (bus.req_ready) begin
                model_accept(st, f3, a, wd);
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got=no_accept want=accept", a);
        end
        @(posedge clk);
        @(negedge clk);
        if (drop) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (pend_r && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pend_r) begin
            errors++;
            $display("FAIL rsp_timeout got=pending want=done");
        end
        @(negedge clk);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] want, input string nm);
        do_req(1'b0, f3, a, 32'd0, 1'b1);
        wait_idle();
        chk(nm, bus.rsp_rdata, want);
    endtask

    task automatic bad(input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input string nm);
        do_req(st, f3, a, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk({nm, "_err"}, bus.rsp_err, 1);
        chk({nm, "_rdata"}, bus.rsp_rdata, 0);
    endtask

    initial begin
        int base;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'd2;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'h1234_5678;
        #1;
        chk("por_ready", bus.req_ready, 0);
        chk("por_ram_we", bus.ram_we, 0);
        repeat (3) @(negedge clk);
        bus.req_valid = 1'b0;
        #2 rstn = 1'b1;
        @(negedge clk);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
        wait_idle();
        chk("sw_ram", ram[4], 32'hDEAD_BEEF);
        chk("sw_err", bus.rsp_err, 0);

        ld(3'd0, 32'h13, 32'hFFFF_FFDE, "lb_13");
        ld(3'd4, 32'h13, 32'h0000_00DE, "lbu_13");
        ld(3'd1, 32'h10, 32'hFFFF_BEEF, "lh_10");
        ld(3'd5, 32'h12, 32'h0000_DEAD, "lhu_12");
        ld(3'd2, 32'h10, 32'hDEAD_BEEF, "lw_10");

        do_req(1'b1, 3'd0, 32'h11, 32'h1234_56AA, 1'b1);
        wait_idle();
        chk("sb_ram", ram[4], 32'hDEAD_AAEF);
        do_req(1'b1, 3'd1, 32'h12, 32'h0000_5555, 1'b1);
        wait_idle();
        chk("sh_ram", ram[4], 32'h5555_AAEF);

        bad(1'b0, 3'd2, 32'h11, "lw_mis");
        bad(1'b1, 3'd1, 32'h13, "sh_mis");
        bad(1'b0, 3'd3, 32'h10, "ld_f3_3");
        bad(1'b1, 3'd4, 32'h10, "st_f3_4");
        chk("err_ram_kept", ram[4], 32'h5555_AAEF);

        base = nrsp;
        do_req(1'b1, 3'd2, 32'h14, 32'h1122_3344, 1'b0);
        do_req(1'b1, 3'd0, 32'h15, 32'h0000_00AB, 1'b0);
        do_req(1'b0, 3'd2, 32'h14, 32'd0, 1'b1);
        wait_idle();
        chk("b2b_count", nrsp - base, 3);
        chk("b2b_rdata", bus.rsp_rdata, 32'h1122_AB44);

        do_req(1'b1, 3'd0, 32'h11, 32'h0000_0077, 1'b1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_ram_we", bus.ram_we, 0);
        chk("abort_ram_addr", bus.ram_addr, 0);
        chk("abort_ram_wdata", bus.ram_wdata, 0);
        chk("abort_ready", bus.req_ready, 0);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("abort_ram_kept", ram[4], 32'h5555_AAEF);
        ld(3'd2, 32'h10, 32'h5555_AAEF, "lw_after_abort");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
